// File: rtl/muldiv_control_if.sv
// rtl/muldiv_control_if.sv - EX-stage HI/LO multiply/divide sequencer bus
interface muldiv_control_if #(
   parameter int WIDTH = 32
);
   logic             valid_in;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             stall;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             busy;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid_in, opcode, funct, rs_val, rt_val,
      input  stall, result, result_valid, busy, div_by_zero, hi, lo
   );

   modport slave (
      input  valid_in, opcode, funct, rs_val, rt_val,
      output stall, result, result_valid, busy, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_control.sv
// rtl/muldiv_control.sv - HI/LO multiply/divide sequencer; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_control #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   muldiv_control_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] F_MFHI     = 6'h10;
   localparam logic [5:0] F_MTHI     = 6'h11;
   localparam logic [5:0] F_MFLO     = 6'h12;
   localparam logic [5:0] F_MTLO     = 6'h13;
   localparam logic [5:0] F_MULT     = 6'h18;
   localparam logic [5:0] F_MULTU    = 6'h19;
   localparam logic [5:0] F_DIV      = 6'h1A;
   localparam logic [5:0] F_DIVU     = 6'h1B;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   dvs_q, dvs_d;     // multiplicand or divisor magnitude
   logic               is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d; // product / quotient sign
   logic               neg_hi_q, neg_hi_d; // remainder sign (follows dividend)
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   rs_q, rs_d;       // dividend as issued, returned in HI on divide by zero
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_class, cls_valid, is_mul_op, is_div_op, is_signed;
   logic               rs_neg, rt_neg, start;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_next, div_next, iter_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               stall_c, result_valid_c;
   logic [WIDTH-1:0]   result_c;

   // Instruction decode and operand magnitude / sign extraction
   always_comb begin
      is_class  = (bus.opcode == OP_SPECIAL) &&
                  ((bus.funct == F_MFHI) || (bus.funct == F_MTHI) ||
                   (bus.funct == F_MFLO) || (bus.funct == F_MTLO) ||
                   (bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                   (bus.funct == F_DIV)  || (bus.funct == F_DIVU));
      cls_valid = bus.valid_in && is_class;
      is_mul_op = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
      is_div_op = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
      is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
      rs_neg    = is_signed && bus.rs_val[WIDTH-1];
      rt_neg    = is_signed && bus.rt_val[WIDTH-1];
      // Two's complement negate of INT_MIN yields 2^(WIDTH-1), the correct unsigned magnitude
      rs_mag    = rs_neg ? (~bus.rs_val + 1'b1) : bus.rs_val;
      rt_mag    = rt_neg ? (~bus.rt_val + 1'b1) : bus.rt_val;
   end

   // One shift-add or restoring-divide step plus the sign fix used on the final step
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, dvs_q};
      div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      iter_next = is_div_q ? div_next : mul_next;
      prod_fix  = neg_lo_q ? (~iter_next + 1'b1) : iter_next;
      quo_fix   = neg_lo_q ? (~iter_next[WIDTH-1:0] + 1'b1) : iter_next[WIDTH-1:0];
      rem_fix   = neg_hi_q ? (~iter_next[2*WIDTH-1:WIDTH] + 1'b1) : iter_next[2*WIDTH-1:WIDTH];
   end

   // Next-state, HI/LO update and combinational stall/result outputs
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      dvs_d          = dvs_q;
      is_div_d       = is_div_q;
      neg_lo_d       = neg_lo_q;
      neg_hi_d       = neg_hi_q;
      dz_d           = dz_q;
      rs_d           = rs_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      stall_c        = 1'b0;
      result_valid_c = 1'b0;
      result_c       = '0;
      start          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cls_valid) begin
               if (bus.funct == F_MFHI) begin
                  result_c       = hi_q;
                  result_valid_c = 1'b1;
               end else if (bus.funct == F_MFLO) begin
                  result_c       = lo_q;
                  result_valid_c = 1'b1;
               end else if (bus.funct == F_MTHI) begin
                  hi_d = bus.rs_val;
               end else if (bus.funct == F_MTLO) begin
                  lo_d = bus.rs_val;
               end else if (is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
                  {hi_d, lo_d} = (rs_neg ^ rt_neg)
                     ? (~({{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag}) + 1'b1)
                     :  ({{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag});
`else
                  start = 1'b1;
`endif
               end else begin
                  start = 1'b1;
               end
            end
         end
         S_BUSY: begin
            // Any HI/LO instruction must wait; it is re-presented until IDLE
            stall_c = cls_valid;
            acc_d   = iter_next;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (dz_q) begin
                  hi_d = rs_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d  = S_BUSY;
         cnt_d    = CW'(WIDTH);
         is_div_d = is_div_op;
         dvs_d    = is_div_op ? rt_mag : rs_mag;
         acc_d    = {{WIDTH{1'b0}}, (is_div_op ? rs_mag : rt_mag)};
         neg_lo_d = rs_neg ^ rt_neg;
         neg_hi_d = rs_neg;
         dz_d     = is_div_op && (bus.rt_val == '0);
         rs_d     = bus.rs_val;
      end
   end

   // State and HI/LO registers; reset discards any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         dvs_q    <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         dz_q     <= 1'b0;
         rs_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         dvs_q    <= dvs_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         dz_q     <= dz_d;
         rs_q     <= rs_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.stall        = stall_c;
   assign bus.result       = result_c;
   assign bus.result_valid = result_valid_c;
   assign bus.busy         = (state_q == S_BUSY);
   assign bus.div_by_zero  = (state_q == S_BUSY) && (cnt_q == CW'(1)) && is_div_q && dz_q;
   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
endmodule

// File: tb/tb_muldiv_control.sv
// tb/tb_muldiv_control.sv - scoreboard bench for muldiv_control
module tb_muldiv_control;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_CYC = 0;
`else
   localparam int MUL_CYC = 32;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   muldiv_control_if #(.WIDTH(32)) dut_if();

   muldiv_control #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every presented result is matched against the oldest expected value
   always @(negedge clk) begin
      if (!rst && dut_if.result_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=0x%08h expected=none", dut_if.result);
         end else begin
            chk(name_q.pop_front(), dut_if.result, exp_q.pop_front());
            chk("no_stall_on_result", {31'b0, dut_if.stall}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      dut_if.valid_in = 1'b1;
      dut_if.opcode   = 6'h00;
      dut_if.funct    = f;
      dut_if.rs_val   = rs;
      dut_if.rt_val   = rt;
      @(posedge clk); #1;
      dut_if.valid_in = 1'b0;
   endtask

   task automatic rd(input logic [5:0] f, input logic [31:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      dut_if.valid_in = 1'b1;
      dut_if.opcode   = 6'h00;
      dut_if.funct    = f;
      @(negedge clk);
      @(posedge clk); #1;
      dut_if.valid_in = 1'b0;
   endtask

   // Starts in cycle 1; returns at the negedge of the first idle cycle
   task automatic wait_done(output int nb, output int nd, output int dc);
      nb = 0; nd = 0; dc = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (dut_if.div_by_zero) begin nd++; dc = c; end
         if (!dut_if.busy) break;
         nb++;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input int cyc, input logic dz,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int nb, nd, dc;
      issue(f, rs, rt);
      wait_done(nb, nd, dc);
      chk({nm, "_busy_cycles"}, nb, cyc);
      chk({nm, "_hi_port"}, dut_if.hi, ehi);
      chk({nm, "_lo_port"}, dut_if.lo, elo);
      chk({nm, "_dz_count"}, nd, dz ? 32'd1 : 32'd0);
      if (dz) chk({nm, "_dz_cycle"}, dc, 32'd32);
      @(posedge clk); #1;
      rd(F_MFHI, ehi, {nm, "_mfhi"});
      rd(F_MFLO, elo, {nm, "_mflo"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      dut_if.valid_in = 1'b0;
      dut_if.opcode   = 6'h00;
      dut_if.funct    = 6'h00;
      dut_if.rs_val   = '0;
      dut_if.rt_val   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy",  {31'b0, dut_if.busy}, 32'd0);
      chk("reset_stall", {31'b0, dut_if.stall}, 32'd0);
      chk("reset_rv",    {31'b0, dut_if.result_valid}, 32'd0);
      chk("reset_dz",    {31'b0, dut_if.div_by_zero}, 32'd0);
      chk("reset_hi",    dut_if.hi, 32'd0);
      chk("reset_lo",    dut_if.lo, 32'd0);
      @(posedge clk); #1;

      run_op("mult_m3x5",   F_MULT,  32'hFFFFFFFD, 32'd5,        MUL_CYC, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("mult_7xm2",   F_MULT,  32'd7,        32'hFFFFFFFE, MUL_CYC, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF2);
      run_op("mult_minsq",  F_MULT,  32'h80000000, 32'h80000000, MUL_CYC, 1'b0, 32'h40000000, 32'h00000000);
      run_op("div_m7d2",    F_DIV,   32'hFFFFFFF9, 32'd2,        32,      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7dm2",    F_DIV,   32'd7,        32'hFFFFFFFE, 32,      1'b0, 32'h00000001, 32'hFFFFFFFD);
      run_op("div_minm1",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32,      1'b0, 32'h00000000, 32'h80000000);
      run_op("divu_100d7",  F_DIVU,  32'd100,      32'd7,        32,      1'b0, 32'h00000002, 32'h0000000E);
      run_op("divu_dz",     F_DIVU,  32'h1234,     32'd0,        32,      1'b1, 32'h00001234, 32'hFFFFFFFF);

      // MULTU with a dependent MFLO held from cycle 1
      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      exp_q.push_back(32'h00000001);
      name_q.push_back("multu_held_mflo");
      dut_if.valid_in = 1'b1;
      dut_if.funct    = F_MFLO;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!dut_if.stall) break;
         n++;
         @(posedge clk); #1;
      end
      chk("multu_stall_cycles", n, MUL_CYC);
      @(posedge clk); #1;
      dut_if.valid_in = 1'b0;
      rd(F_MFHI, 32'hFFFFFFFE, "multu_mfhi");

      // Non-class instructions are ignored
      dut_if.valid_in = 1'b1;
      dut_if.opcode   = 6'h23;
      dut_if.funct    = F_MULT;
      @(posedge clk); #1;
      dut_if.opcode   = 6'h00;
      dut_if.funct    = 6'h20;
      @(negedge clk);
      chk("ignored_no_stall", {31'b0, dut_if.stall}, 32'd0);
      @(posedge clk); #1;
      dut_if.valid_in = 1'b0;
      @(negedge clk);
      chk("ignored_not_busy", {31'b0, dut_if.busy}, 32'd0);
      @(posedge clk); #1;
      rd(F_MFLO, 32'h00000001, "ignored_lo_kept");

      issue(F_MTHI, 32'hDEADBEEF, 32'd0);
      rd(F_MFHI, 32'hDEADBEEF, "mthi_mfhi");

      // Reset in cycle 10 of a divide
      issue(F_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", {31'b0, dut_if.busy}, 32'd0);
      chk("rst_mid_hi",   dut_if.hi, 32'd0);
      chk("rst_mid_lo",   dut_if.lo, 32'd0);
      @(posedge clk); #1;
      issue(F_MTLO, 32'hA5A5A5A5, 32'd0);
      rd(F_MFLO, 32'hA5A5A5A5, "mtlo_after_rst");

      repeat (3) @(posedge clk);
      chk("pending_results", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
